// File: rtl/gate_lab_pkg.sv
// Shared types and constants for the 4-input gate-lab stimulus path.
package gate_lab_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned PATTERN_COUNT       = 16;
    localparam logic [3:0]  LAST_INDEX          = 4'hF;
    localparam int unsigned DEFAULT_HOLD_CYCLES = 20;

endpackage

// File: rtl/input4_pattern_gen_hold_timer.sv
// Per-pattern hold timer: counts enabled cycles and flags the terminal one.
module hold_timer
    import gate_lab_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned    CW     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0]  TC_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    assign tc = enable && (count == TC_VAL);

    // Count enabled cycles; wrap on terminal count, hold while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/input4_pattern_gen.sv
// Sweeps a/b/c/d through 0000..1111, holding each pattern HOLD_CYCLES clocks.
module input4_pattern_gen
    import gate_lab_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned LOOP        = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic pause,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic valid,
    output logic last,
    output logic busy,
    output logic done
);

    localparam int unsigned IDX_W = $clog2(PATTERN_COUNT);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] next_index;
    logic             timer_clear;
    logic             timer_enable;
    logic             tc;

    assign next_index   = index + IDX_W'(1);
    assign timer_clear  = (state != RUN);
    assign timer_enable = (state == RUN) && !pause;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .tc     (tc)
    );

    // Sequencer FSM with registered pattern and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            index        <= '0;
            {a, b, c, d} <= '0;
            valid        <= 1'b0;
            last         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        index        <= '0;
                        {a, b, c, d} <= '0;
                        valid        <= 1'b1;
                        last         <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                RUN: begin
                    if (tc) begin
                        if ((index == LAST_INDEX) && (LOOP == 0)) begin
                            state        <= DONE;
                            index        <= '0;
                            {a, b, c, d} <= '0;
                            valid        <= 1'b0;
                            last         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            // index wraps 15 -> 0 by its own width when looping
                            index        <= next_index;
                            {a, b, c, d} <= next_index;
                            last         <= (next_index == LAST_INDEX);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input4_pattern_gen.sv
// Bench for input4_pattern_gen: one non-looping HOLD=20 instance and one looping HOLD=1 instance.
module tb_input4_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, pause0, start1, pause1;
    logic a0, b0, c0, d0, valid0, last0, busy0, done0;
    logic a1, b1, c1, d1, valid1, last1, busy1, done1;

    input4_pattern_gen #(.HOLD_CYCLES(20), .LOOP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pause(pause0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .valid(valid0), .last(last0), .busy(busy0), .done(done0)
    );

    input4_pattern_gen #(.HOLD_CYCLES(1), .LOOP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .valid(valid1), .last(last1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a sweep is a count of unpaused RUN cycles; pattern = count / hold.
    int hold_c[2] = '{20, 1};
    bit loop_m[2] = '{1'b0, 1'b1};
    bit m_run[2]   = '{1'b0, 1'b0};
    bit m_donep[2] = '{1'b0, 1'b0};
    int m_u[2]     = '{0, 0};

    always @(posedge clk) begin : model
        logic st, pa;
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? start0 : start1;
            pa = (i == 0) ? pause0 : pause1;
            if (!rst_n) begin
                m_run[i] = 1'b0; m_donep[i] = 1'b0; m_u[i] = 0;
            end else if (m_donep[i]) begin
                m_donep[i] = 1'b0;
            end else if (!m_run[i]) begin
                if (st) begin
                    m_run[i] = 1'b1; m_u[i] = 0;
                end
            end else if (!pa) begin
                m_u[i]++;
                if (m_u[i] == 16 * hold_c[i]) begin
                    m_u[i] = 0;
                    if (!loop_m[i]) begin
                        m_run[i] = 1'b0; m_donep[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] expect_vec(input int i);
        int p;
        p = m_run[i] ? (m_u[i] / hold_c[i]) : 0;
        return {p[3:0], m_run[i], m_run[i] && (p == 15), m_run[i] || m_donep[i], m_donep[i]};
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dut0_outputs", {a0, b0, c0, d0, valid0, last0, busy0, done0}, expect_vec(0));
            check("dut1_outputs", {a1, b1, c1, d1, valid1, last1, busy1, done1}, expect_vec(1));
        end
    end

    // Drives dut0 for ncyc cycles after a start set up by the caller and gathers timing facts.
    task automatic sweep0(input int ncyc, input int p_from, input int p_to, input int s_at,
                          input int r_at, input int probe,
                          output int v_cnt, output int first_last, output int last_cnt,
                          output int done_at, output int done_cnt, output int busy_drop,
                          output int p5_cnt, output int p0_cnt, output int probe_val);
        v_cnt = 0; first_last = -1; last_cnt = 0; done_at = -1; done_cnt = 0;
        busy_drop = -1; p5_cnt = 0; p0_cnt = 0; probe_val = -1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            #1;
            if (valid0) v_cnt++;
            if (last0) begin
                last_cnt++;
                if (first_last < 0) first_last = n;
            end
            if (done0) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (!busy0 && busy_drop < 0) busy_drop = n;
            if (valid0 && {a0, b0, c0, d0} == 4'd5) p5_cnt++;
            if (valid0 && {a0, b0, c0, d0} == 4'd0) p0_cnt++;
            if (n == probe) probe_val = {a0, b0, c0, d0};
            start0 = (n == s_at);
            pause0 = (n >= p_from) && (n <= p_to);
            rst_n  = (n != r_at);
        end
    endtask

    initial begin
        int v, fl, lc, da, dc, bd, p5, p0, pv;
        rst_n = 1'b0; start0 = 1'b0; pause0 = 1'b0; start1 = 1'b0; pause1 = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("reset_dut0", {a0, b0, c0, d0, valid0, last0, busy0, done0}, 8'h00);
        check("reset_dut1", {a1, b1, c1, d1, valid1, last1, busy1, done1}, 8'h00);
        rst_n = 1'b1;

        // Plain sweep
        start0 = 1'b1;
        sweep0(330, 0, -1, 0, 0, 21, v, fl, lc, da, dc, bd, p5, p0, pv);
        check("t1_valid_cycles", v, 320);
        check("t1_first_last", fl, 301);
        check("t1_last_cycles", lc, 20);
        check("t1_done_at", da, 321);
        check("t1_done_count", dc, 1);
        check("t1_busy_drop", bd, 322);
        check("t1_p5_cycles", p5, 20);
        check("t1_pattern_at_21", pv, 1);

        // Pause 7 cycles during 0101
        start0 = 1'b1;
        sweep0(340, 105, 111, 0, 0, 128, v, fl, lc, da, dc, bd, p5, p0, pv);
        check("t2_p5_cycles", p5, 27);
        check("t2_p0_cycles", p0, 20);
        check("t2_valid_cycles", v, 327);
        check("t2_done_at", da, 328);
        check("t2_pattern_at_128", pv, 6);

        // Reset while pattern 9 is driven
        start0 = 1'b1;
        sweep0(200, 0, -1, 0, 185, 185, v, fl, lc, da, dc, bd, p5, p0, pv);
        check("t3_pattern_at_reset", pv, 9);
        check("t3_valid_cycles", v, 185);
        check("t3_busy_drop", bd, 186);
        check("t3_done_count", dc, 0);
        check("t3_idle_outputs", {a0, b0, c0, d0, valid0, last0, busy0, done0}, 8'h00);

        // Restart, with start re-asserted during 0011
        start0 = 1'b1;
        sweep0(330, 0, -1, 65, 0, 81, v, fl, lc, da, dc, bd, p5, p0, pv);
        check("t4_restart_p0_cycles", p0, 20);
        check("t4_pattern_at_81", pv, 4);
        check("t4_valid_cycles", v, 320);
        check("t4_done_at", da, 321);

        // start and pause together, pause held 5 cycles
        start0 = 1'b1; pause0 = 1'b1;
        sweep0(340, 1, 5, 0, 0, 26, v, fl, lc, da, dc, bd, p5, p0, pv);
        check("t6_p0_cycles", p0, 25);
        check("t6_pattern_at_26", pv, 1);
        check("t6_done_at", da, 326);

        // HOLD_CYCLES=1 looping instance
        start1 = 1'b1;
        lc = 0; dc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (last1) lc++;
            if (done1) dc++;
            if (n == 16) check("t5_pattern_at_16", {a1, b1, c1, d1, last1}, 5'b11111);
            if (n == 17) check("t5_wrap_at_17", {a1, b1, c1, d1, valid1, last1}, 6'b000010);
            if (n == 23) check("t5_pattern_at_23", {a1, b1, c1, d1}, 4'd6);
            start1 = 1'b0;
            pause1 = (n >= 30) && (n <= 32);
        end
        check("t5_last_pulses", lc, 2);
        check("t5_done_count", dc, 0);
        check("t5_pattern_after_pause", {a1, b1, c1, d1}, 4'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input4_pattern_gen.md
Name: input4_pattern_gen

Overview:
- Stimulus sequencer that sits directly upstream of the 4-input gate-lab block and drives its a/b/c/d inputs.
- On start it walks all 16 input combinations in binary order, 0000 to 1111, with a as MSB and d as LSB.
- Each pattern is held for a programmable number of clocks, so the downstream e/f/g outputs settle and can be sampled.
- Provides busy/valid/last/done status so a checker or capture stage can align to each pattern.

Parameters:
- HOLD_CYCLES, 20, clocks each pattern is held; legal range 1..255.
- LOOP, 0, 0 = stop after pattern 15; 1 = wrap to pattern 0 and run until reset.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle (or level) request to begin a sweep; honoured only in IDLE.
- pause  input  1  while high, freeze hold counter and pattern index; outputs hold their value.
- a  output  1  pattern bit 3 (MSB).
- b  output  1  pattern bit 2.
- c  output  1  pattern bit 1.
- d  output  1  pattern bit 0 (LSB).
- valid  output  1  high while a/b/c/d carry a live pattern (RUN state).
- last  output  1  high while pattern 15 (1111) is being driven.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a non-looping sweep completes.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces: state=IDLE, index=0, hold count=0, and a=b=c=d=valid=last=busy=done=0. Reset mid-sweep aborts immediately; no done pulse is issued.
- States and transitions:
  - IDLE: outputs zero. start=1 at edge k -> RUN with index=0, hold=0. valid=1 and abcd=0000 are visible from cycle k+1.
  - RUN: {a,b,c,d}=index, all registered outputs.
    - Each cycle with pause=0, hold increments.
    - When hold==HOLD_CYCLES-1 and pause=0, hold clears and index advances on that edge.
    - Each pattern is therefore visible for exactly HOLD_CYCLES unpaused cycles.
    - Advancing from index 15 with LOOP=1: index wraps to 0, stays in RUN, and no done pulse is issued.
    - Advancing from index 15 with LOOP=0: -> DONE.
  - DONE: lasts one cycle. done=1, busy=1, valid=0, abcd=0000. Next edge -> IDLE.
- Total sweep with LOOP=0 and no pause: valid high for 16*HOLD_CYCLES cycles. The done pulse appears on the cycle after the last valid cycle.
- pause:
  - Pause in IDLE or DONE has no effect.
  - Pause on the terminal-count cycle blocks the advance; the pattern stretches until pause drops.
- start while busy is ignored; no restart and no queuing.
- start and pause both high in IDLE: enter RUN normally; the hold counter is then frozen from cycle k+1.
- HOLD_CYCLES=1: the pattern changes every unpaused cycle; last is high for exactly one cycle.
- Hold counter width is clog2(HOLD_CYCLES)+1, minimum 1 bit. The index is 4 bits and wraps naturally.

Decomposition:
- Shared package (gate_lab_pkg):
  - state enum {IDLE, RUN, DONE}.
  - PATTERN_COUNT=16.
  - LAST_INDEX=4'hF.
  - Default HOLD_CYCLES constant.
- One sub-module: hold_timer, parameterised by HOLD_CYCLES.
  - Inputs: clk, rst_n, clear, enable.
  - Output: tc (terminal count, combinational on count==HOLD_CYCLES-1 && enable).
- The top module holds the FSM, the index register and the output registers.

Test Plan:
1. Reset then start pulse, HOLD_CYCLES=20, LOOP=0:
   - abcd steps 0000..1111, each held exactly 20 cycles.
   - last high for cycles 301..320 after start.
   - done pulses once at cycle 321.
   - busy drops at 322.
2. pause high for 7 cycles during pattern 0101:
   - 0101 is visible for 27 cycles.
   - All other patterns are 20 cycles; the done pulse is shifted by +7.
3. Assert rst_n=0 while index=9:
   - Next cycle all outputs are 0 and state is IDLE; no done pulse.
   - A new start restarts from 0000.
4. start re-asserted during RUN at pattern 0011: no effect; the sequence continues to 0100 on schedule.
5. HOLD_CYCLES=1, LOOP=1:
   - Patterns change every cycle.
   - After 1111 the next cycle is 0000 with valid still high.
   - done never asserts; last pulses every 16 cycles.
6. start and pause high together in IDLE, pause held 5 cycles: 0000 is visible for 25 cycles, then the normal sweep follows.
